// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - M-extension divide sequencer between EX, the iterative divider and writeback.
// Optional one-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic [4:0]  reg_waddr_i,
  input  logic        flush_i,
  output logic        div_start_o,
  output logic [2:0]  div_op_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  output logic [4:0]  div_reg_waddr_o,
  input  logic [31:0] div_result_i,
  input  logic        div_ready_i,
  input  logic        div_busy_i,
  output logic        hold_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_waddr_o,
  output logic [31:0] wb_wdata_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    WB    = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] dividend_q, dividend_d;
  logic [31:0] divisor_q, divisor_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        candidate;
  logic        accept;
  logic        in_run;
  logic        run_done;
  logic        cache_hit;
  logic [31:0] cache_result;

  // Divide ops are exactly the funct3 codes with the top bit set.
  assign candidate = rst && (state_q == IDLE) && req_valid_i && op_i[2] && !flush_i;
  assign accept    = candidate && !div_busy_i;
  assign in_run    = (state_q == RUN);
  assign run_done  = in_run && !flush_i && div_ready_i;

`ifdef DIV_RESULT_CACHE_EN
  logic        cache_valid_q;
  logic [2:0]  cache_op_q;
  logic [31:0] cache_dividend_q;
  logic [31:0] cache_divisor_q;
  logic [31:0] cache_result_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cache_valid_q    <= 1'b0;
      cache_op_q       <= '0;
      cache_dividend_q <= '0;
      cache_divisor_q  <= '0;
      cache_result_q   <= '0;
    end else if (run_done) begin
      cache_valid_q    <= 1'b1;
      cache_op_q       <= op_q;
      cache_dividend_q <= dividend_q;
      cache_divisor_q  <= divisor_q;
      cache_result_q   <= div_result_i;
    end
  end

  assign cache_hit    = cache_valid_q && (cache_op_q == op_i) &&
                        (cache_dividend_q == dividend_i) && (cache_divisor_q == divisor_i);
  assign cache_result = cache_result_q;
`else
  assign cache_hit    = 1'b0;
  assign cache_result = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d       = op_i;
          dividend_d = dividend_i;
          divisor_d  = divisor_i;
          waddr_d    = reg_waddr_i;
          if (cache_hit) begin
            wdata_d = cache_result;
            state_d = WB;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // A kill wins over a result arriving in the same cycle.
        if (flush_i) begin
          state_d = DRAIN;
        end else if (div_ready_i) begin
          wdata_d = div_result_i;
          state_d = WB;
        end
      end
      DRAIN:   state_d = IDLE;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign div_start_o     = in_run;
  assign div_op_o        = in_run ? op_q       : '0;
  assign div_dividend_o  = in_run ? dividend_q : '0;
  assign div_divisor_o   = in_run ? divisor_q  : '0;
  assign div_reg_waddr_o = in_run ? waddr_q    : '0;

  assign hold_o     = candidate || in_run;
  assign wb_we_o    = (state_q == WB);
  assign wb_waddr_o = wb_we_o ? waddr_q : '0;
  assign wb_wdata_o = wb_we_o ? wdata_q : '0;

endmodule
